fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 IMEM_ADDR  output  32  instruction memory byte address; equals PC.
REQ-005 IMEM_READ  output  1  instruction memory read request.
REQ-006 IMEM_RDATA  input  32  instruction word from memory.
REQ-007 IMEM_BUSYWAIT  input  1  high while memory has not completed the read.
REQ-008 INSTRUCTION  output  32  latched current instruction.
REQ-009 OPCODE  output  4  INSTRUCTION[31:28], feeds the control unit.
REQ-010 INSTR_VALID  output  1  INSTRUCTION/OPCODE valid for decode and execute.
REQ-011 STALL  input  1  downstream hold; freezes the execute state.
REQ-012 BRAZ, BRANZ, BRAUNCOND  input  1 each  branch controls from the control unit.
REQ-013 ZERO  input  1  ALU zero flag for the current instruction.
REQ-014 PC  output  32  address of the current instruction.
REQ-015 ILLEGAL  output  1  sticky flag: an undefined opcode was executed.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT.
REQ-017 IDLE SHALL hold all outputs at reset values and move to FETCH on the next edge.
REQ-018 In FETCH: IMEM_READ=1 and IMEM_ADDR=PC; if IMEM_BUSYWAIT=0 at the edge, INSTRUCTION<=IMEM_RDATA and next state is EXEC; otherwise stay in FETCH.
REQ-019 In EXEC: INSTR_VALID=1 and IMEM_READ=0; while STALL=1, stay in EXEC with PC and INSTRUCTION unchanged.
REQ-020 In EXEC with STALL=0, the edge SHALL update PC and return to FETCH.
REQ-021 taken = BRAUNCOND | (BRAZ & ZERO) | (BRANZ & ~ZERO); any input that is not exactly 1 counts as 0.
REQ-022 Next PC SHALL be PC+4+(sign-extended INSTRUCTION[7:0] << 2) when taken, else PC+4; arithmetic is modulo 2^32 and wraps silently.
REQ-023 An OPCODE in 4'b1100-4'b1111 in EXEC with STALL=0 SHALL set ILLEGAL=1, leave PC unchanged and move to HALT.
REQ-024 HALT SHALL keep IMEM_READ=0 and INSTR_VALID=0 and hold PC and INSTRUCTION; only RESET exits HALT.
REQ-025 Minimum throughput: 2 cycles per instruction (FETCH 1 + EXEC 1) with zero wait states; each busywait cycle adds 1.
REQ-026 IMEM_READ and INSTR_VALID SHALL never be high in the same cycle.
REQ-027 When more than one branch input is high, taken SHALL follow the OR in REQ-021; there is no priority.
REQ-028 IMEM_RDATA SHALL be ignored in every state except FETCH with IMEM_BUSYWAIT=0.

Reset
REQ-029 RESET=1 SHALL immediately force state=IDLE, PC=RESET_PC, INSTRUCTION=0, INSTR_VALID=0, IMEM_READ=0 and ILLEGAL=0, regardless of the clock.
REQ-030 Reset during an outstanding fetch SHALL drop IMEM_READ asynchronously; the in-flight memory data SHALL be discarded.
REQ-031 After RESET falls, the first IMEM_READ SHALL assert on the cycle following the first rising edge.

Verification
REQ-032 Sequential fetch: zero-wait memory, opcodes 0000 for 3 words -> PC goes 0,4,8,12; INSTR_VALID pulses one cycle every 2 cycles.
REQ-033 Busywait: IMEM_BUSYWAIT held high 3 cycles at PC=8 -> FETCH lasts 4 cycles; INSTRUCTION is unchanged until the completing edge.
REQ-034 Branches: at PC=16, offset 8'hFE with BRAZ=1, ZERO=1 -> next PC=12; the same with ZERO=0 -> 20; BRANZ=1, ZERO=0, offset 8'h03 -> 32; BRAUNCOND=1 -> taken regardless of ZERO.
REQ-035 Stall and wrap: STALL=1 for 5 cycles in EXEC -> INSTR_VALID stays 1 and PC is constant; PC=32'hFFFF_FFFC, no branch -> next PC=0.
REQ-036 Illegal opcode: OPCODE=4'b1101 at PC=40 -> ILLEGAL=1, PC stays 40, IMEM_READ stays 0 for 10 or more cycles until RESET.
REQ-037 Reset mid-fetch: RESET asserted between edges while IMEM_BUSYWAIT=1 -> IMEM_READ=0 and PC=RESET_PC before the next edge.

Source files
------------

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read channel between the fetch unit and the memory.
//
// Signals:
//   imem_addr      byte address of the requested instruction (fetch -> mem)
//   imem_read      read request, high for the whole fetch    (fetch -> mem)
//   imem_rdata     instruction word                          (mem -> fetch)
//   imem_busywait  high while the read is not yet complete   (mem -> fetch)
//
// Modports:
//   master  used by the fetch unit
//   slave   used by the instruction memory (or its model)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_busywait;

    modport master (
        output imem_addr,
        output imem_read,
        input  imem_rdata,
        input  imem_busywait
    );

    modport slave (
        input  imem_addr,
        input  imem_read,
        output imem_rdata,
        output imem_busywait
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch / program-counter sequencer. Alternates FETCH (read one
// word from instruction memory, waiting out busywait) and EXEC (present the
// latched instruction to decode/execute, then step or branch the PC). An
// undefined opcode (4'b1100-4'b1111) parks the unit in HALT until reset.
//
// Parameters:
//   RESET_PC        PC value loaded on reset
//
// Ports:
//   clk             system clock, rising-edge active
//   rst             asynchronous, active-high reset
//   imem_bus        instruction memory read channel (master side)
//   i_stall         downstream hold; freezes EXEC
//   i_braz          branch if ALU result zero
//   i_branz         branch if ALU result non-zero
//   i_braucond      unconditional branch
//   i_zero          ALU zero flag for the current instruction
//   o_instruction   latched current instruction
//   o_opcode        o_instruction[31:28]
//   o_instr_valid   instruction valid for decode/execute (EXEC only)
//   o_pc            address of the current instruction
//   o_illegal       sticky: an undefined opcode was executed
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_if.master        imem_bus,
    input  logic                i_stall,
    input  logic                i_braz,
    input  logic                i_branz,
    input  logic                i_braucond,
    input  logic                i_zero,
    output logic [31:0]         o_instruction,
    output logic [3:0]          o_opcode,
    output logic                o_instr_valid,
    output logic [31:0]         o_pc,
    output logic                o_illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic        r_instr_valid;
    logic        r_imem_read;
    logic        r_illegal;

    logic        w_braz;
    logic        w_branz;
    logic        w_braucond;
    logic        w_zero;
    logic        w_taken;
    logic        w_illegal_op;
    logic [31:0] w_offset;
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_next;

    // NOTE: '=== 1'b1' makes an X/Z control behave as 0 in simulation; in
    // hardware it is an ordinary compare, so both views agree on 0/1 inputs.
    assign w_braz     = (i_braz     === 1'b1);
    assign w_branz    = (i_branz    === 1'b1);
    assign w_braucond = (i_braucond === 1'b1);
    assign w_zero     = (i_zero     === 1'b1);

    // All conditions are OR-ed; no branch input has priority over another.
    assign w_taken = w_braucond | (w_braz & w_zero) | (w_branz & ~w_zero);

    // Word offset in the low byte, sign-extended and scaled to bytes.
    assign w_offset  = {{22{r_instruction[7]}}, r_instruction[7:0], 2'b00};
    assign w_pc_seq  = r_pc + 32'd4;
    assign w_pc_next = w_taken ? (w_pc_seq + w_offset) : w_pc_seq;

    // Opcodes 4'b1100..4'b1111 are undefined.
    assign w_illegal_op = (r_instruction[31:30] == 2'b11);

    // NOTE: every register in this block uses non-blocking assignment so all
    // state updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
            r_imem_read   <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Read request is registered, so it rises on the edge
                    // that enters FETCH.
                    r_state     <= S_FETCH;
                    r_imem_read <= 1'b1;
                end

                S_FETCH: begin
                    if (!imem_bus.imem_busywait) begin
                        r_instruction <= imem_bus.imem_rdata;
                        r_imem_read   <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (!i_stall) begin
                        r_instr_valid <= 1'b0;
                        if (w_illegal_op) begin
                            // PC stays on the offending instruction.
                            r_illegal <= 1'b1;
                            r_state   <= S_HALT;
                        end else begin
                            r_pc        <= w_pc_next;
                            r_imem_read <= 1'b1;
                            r_state     <= S_FETCH;
                        end
                    end
                end

                S_HALT: begin
                    // Terminal until reset; everything holds.
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_bus.imem_addr = r_pc;
    assign imem_bus.imem_read = r_imem_read;

    assign o_instruction = r_instruction;
    assign o_opcode      = r_instruction[31:28];
    assign o_instr_valid = r_instr_valid;
    assign o_pc          = r_pc;
    assign o_illegal     = r_illegal;

    // Fetch and execute phases never overlap.
    a_read_valid_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(r_imem_read && r_instr_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit as instruction memory plus control unit. Every fetched
// instruction pushes its expected {pc, word} into a scoreboard queue; an
// independent monitor pops and compares whenever INSTR_VALID rises. The next
// PC is predicted from the branch rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        int          bw;
        int          st;
        logic        braz;
        logic        branz;
        logic        brau;
        logic        zero;
        logic [31:0] next_pc;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_stall;
    logic        i_braz;
    logic        i_branz;
    logic        i_braucond;
    logic        i_zero;
    logic [31:0] o_instruction;
    logic [3:0]  o_opcode;
    logic        o_instr_valid;
    logic [31:0] o_pc;
    logic        o_illegal;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_bus      (bus),
        .i_stall       (i_stall),
        .i_braz        (i_braz),
        .i_branz       (i_branz),
        .i_braucond    (i_braucond),
        .i_zero        (i_zero),
        .o_instruction (o_instruction),
        .o_opcode      (o_opcode),
        .o_instr_valid (o_instr_valid),
        .o_pc          (o_pc),
        .o_illegal     (o_illegal)
    );

    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_pc;
    logic        prev_valid = 1'b0;
    dir_t        dir[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            check1("read_valid_exclusive", bus.imem_read & o_instr_valid, 1'b0);
            if (bus.imem_read && sb_q.size() > 0)
                check("fetch_addr", bus.imem_addr, sb_q[0].pc);
            if (o_instr_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("valid_without_fetch", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", o_pc, e.pc);
                    check("sb_instr", o_instruction, e.instr);
                    check("sb_opcode", {28'b0, o_opcode}, {28'b0, e.instr[31:28]});
                end
            end
            prev_valid = o_instr_valid;
        end
    end

    task automatic wait_read();
        int n = 0;
        while (bus.imem_read !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("fetch_started", bus.imem_read, 1'b1);
    endtask

    // One full instruction: FETCH with bw wait states, EXEC with st stalls,
    // then the PC-update edge. Called at a falling edge.
    task automatic run_instr(input logic [31:0] word, input int bw, input int st,
                             input logic braz, input logic branz,
                             input logic brau, input logic zero);
        exp_t              e;
        logic [31:0]       held;
        logic              taken;
        logic signed [31:0] off;
        wait_read();
        e.pc    = m_pc;
        e.instr = word;
        sb_q.push_back(e);
        check("pc_at_fetch", o_pc, m_pc);
        held = o_instruction;
        for (int i = 0; i < bw; i++) begin
            bus.imem_busywait = 1'b1;
            bus.imem_rdata    = $urandom;
            @(negedge clk);
            check1("busy_read_held", bus.imem_read, 1'b1);
            check("busy_instr_held", o_instruction, held);
        end
        bus.imem_busywait = 1'b0;
        bus.imem_rdata    = word;
        @(negedge clk);
        bus.imem_busywait = 1'($urandom);
        bus.imem_rdata    = $urandom;
        check1("exec_valid", o_instr_valid, 1'b1);
        check1("exec_no_read", bus.imem_read, 1'b0);
        for (int i = 0; i < st; i++) begin
            i_stall = 1'b1;
            {i_braz, i_branz, i_braucond, i_zero} = 4'($urandom);
            @(negedge clk);
            check1("stall_valid", o_instr_valid, 1'b1);
            check("stall_pc", o_pc, m_pc);
            check("stall_instr", o_instruction, word);
        end
        i_stall    = 1'b0;
        i_braz     = braz;
        i_branz    = branz;
        i_braucond = brau;
        i_zero     = zero;
        @(negedge clk);
        i_stall = 1'($urandom);
        {i_braz, i_branz, i_braucond, i_zero} = 4'($urandom);
        if (word[31:28] >= 4'd12) begin
            check1("illegal_set", o_illegal, 1'b1);
            check("illegal_pc_held", o_pc, m_pc);
            check1("illegal_no_read", bus.imem_read, 1'b0);
            check1("illegal_no_valid", o_instr_valid, 1'b0);
        end else begin
            taken = brau || (braz && zero) || (branz && !zero);
            off   = 32'($signed(word[7:0]));
            m_pc  = m_pc + 32'd4 + (taken ? 32'(off * 32'sd4) : 32'd0);
            check("next_pc", o_pc, m_pc);
            check1("refetch_read", bus.imem_read, 1'b1);
            check1("refetch_no_valid", o_instr_valid, 1'b0);
            check1("no_illegal", o_illegal, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // word, bw, st, braz, branz, brau, zero, expected next PC
        dir[0]  = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4};
        dir[1]  = '{32'h0AAA_AA55, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8};
        dir[2]  = '{32'h0000_00F0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12};
        dir[3]  = '{32'hB000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd16};
        dir[4]  = '{32'h1000_00FE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd12};
        dir[5]  = '{32'h2000_0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd16};
        dir[6]  = '{32'h1000_00FE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd20};
        dir[7]  = '{32'h3000_00FD, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd12};
        dir[8]  = '{32'h2000_0000, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd16};
        dir[9]  = '{32'h4000_0003, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd32};
        dir[10] = '{32'h5000_0001, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd40};
        dir[11] = '{32'h6000_0080, 0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FE2C};
        dir[12] = '{32'h7000_0073, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC};
        dir[13] = '{32'h8000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

        i_stall = 1'b0; i_braz = 1'b0; i_branz = 1'b0; i_braucond = 1'b0; i_zero = 1'b0;
        bus.imem_busywait = 1'b0;
        bus.imem_rdata    = 32'hDEAD_BEEF;

        // Asynchronous reset, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_pc", o_pc, RESET_PC);
        check("rst_instr", o_instruction, 32'h0);
        check1("rst_valid", o_instr_valid, 1'b0);
        check1("rst_read", bus.imem_read, 1'b0);
        check1("rst_illegal", o_illegal, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        m_pc = RESET_PC;
        check1("idle_no_read", bus.imem_read, 1'b0);
        @(posedge clk);
        #1;
        check1("first_read_after_edge", bus.imem_read, 1'b1);
        check("first_addr", bus.imem_addr, RESET_PC);
        @(negedge clk);

        // Directed: sequential, busywait, branches, stall, multi-branch, wrap.
        for (int i = 0; i < 14; i++) begin
            run_instr(dir[i].word, dir[i].bw, dir[i].st,
                      dir[i].braz, dir[i].branz, dir[i].brau, dir[i].zero);
            check("dir_next_pc", o_pc, dir[i].next_pc);
        end

        // Randomized legal instructions.
        for (int i = 0; i < 300; i++) begin
            run_instr({4'($urandom_range(0, 11)), 28'($urandom)},
                      $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset between edges during a busy fetch.
        wait_read();
        bus.imem_busywait = 1'b1;
        bus.imem_rdata    = $urandom;
        @(posedge clk);
        #3;
        check1("pre_reset_read", bus.imem_read, 1'b1);
        rst = 1'b1;
        #1;
        check1("midfetch_read_dropped", bus.imem_read, 1'b0);
        check("midfetch_pc", o_pc, RESET_PC);
        check("midfetch_instr", o_instruction, 32'h0);
        check1("midfetch_valid", o_instr_valid, 1'b0);
        sb_q.delete();
        m_pc = RESET_PC;
        @(negedge clk);
        rst = 1'b0;
        bus.imem_busywait = 1'b0;
        @(negedge clk);

        // Illegal opcode at PC=40, then HALT until reset.
        run_instr(32'h0000_0009, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("to_pc40", o_pc, 32'd40);
        run_instr(32'hD000_0000, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus.imem_busywait = 1'($urandom);
            bus.imem_rdata    = $urandom;
            @(negedge clk);
            check1("halt_no_read", bus.imem_read, 1'b0);
            check1("halt_no_valid", o_instr_valid, 1'b0);
            check("halt_pc", o_pc, 32'd40);
            check("halt_instr", o_instruction, 32'hD000_0000);
            check1("halt_illegal", o_illegal, 1'b1);
        end
        rst = 1'b1;
        #1;
        check1("reset_clears_illegal", o_illegal, 1'b0);
        check("reset_pc_after_halt", o_pc, RESET_PC);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check1("restart_after_halt", bus.imem_read, 1'b1);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
